operand_fetch_stage: RTL



---
 rtl/operand_fetch_stage.sv | 116 +++++++++++
 1 files changed

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: 8x16 register file with one shared read port, fetching A then B
// and holding them for the shifter under valid/ready. Optional OPFETCH_BYPASS_EN forwards same-cycle writes.
//
// state  | meaning
// IDLE   | ready for a new request, indices/shift code captured on accept
// READ_A | read port serves latched rd_a into A_out
// READ_B | read port serves latched rd_b into B_out, shift code to shift_out
// HOLD   | operands valid and stable until out_ready
module operand_fetch_stage #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write,
    input  logic [$clog2(NREG)-1:0]  writenum,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [$clog2(NREG)-1:0]  rd_a,
    input  logic [$clog2(NREG)-1:0]  rd_b,
    input  logic [1:0]               shift_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        A_out,
    output logic [DATA_W-1:0]        B_out,
    output logic [1:0]               shift_out
);

    localparam int IDX_W = $clog2(NREG);

    typedef enum logic [1:0] {IDLE, READ_A, READ_B, HOLD} state_t;

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  regs [NREG];
    logic [IDX_W-1:0]   lat_a, lat_b;
    logic [1:0]         lat_shift;
    logic [IDX_W-1:0]   rd_idx;
    logic [DATA_W-1:0]  rd_data;
    logic [DATA_W-1:0]  rd_fwd;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = READ_A;
            READ_A:  state_nxt = READ_B;
            READ_B:  state_nxt = HOLD;
            HOLD:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        out_valid = (state == HOLD);
    end

    // Reset takes priority over a coincident write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (write) begin
            regs[writenum] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_a     <= '0;
            lat_b     <= '0;
            lat_shift <= '0;
        end else if (state == IDLE && req_valid) begin
            lat_a     <= rd_a;
            lat_b     <= rd_b;
            lat_shift <= shift_in;
        end
    end

    // Single shared read port: index is chosen by which operand is being fetched.
    assign rd_idx  = (state == READ_A) ? lat_a : lat_b;
    assign rd_data = regs[rd_idx];

`ifdef OPFETCH_BYPASS_EN
    assign rd_fwd = (write && (writenum == rd_idx)) ? data_in : rd_data;
`else
    assign rd_fwd = rd_data;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            A_out     <= '0;
            B_out     <= '0;
            shift_out <= '0;
        end else begin
            case (state)
                READ_A: A_out <= rd_fwd;
                READ_B: begin
                    B_out     <= rd_fwd;
                    shift_out <= lat_shift;
                end
                default: ;
            endcase
        end
    end

endmodule
